// File: rtl/pio_input_conditioner.sv
// rtl/pio_input_conditioner.sv - key/switch sync, debounce, sticky key events (PIO_KEY_STICKY_EN), switch change counter
module pio_input_conditioner #(
  parameter int N_KEYS          = 4,
  parameter int N_SW            = 18,
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N_KEYS-1:0] key_n_raw,
  input  logic [N_SW-1:0]   sw_raw,
  input  logic              clr_req,
  output logic [31:0]       keys_word,
  output logic [31:0]       switches_word
);

  localparam int NB = N_KEYS + N_SW;
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [NB-1:0] KEY_MASK = {{N_SW{1'b0}}, {N_KEYS{1'b1}}};

  logic [NB-1:0]     sync1, sync2, synced, stable, accept;
  logic [CW-1:0]     db_cnt [NB];
  logic [N_KEYS-1:0] key_flags;
  logic [7:0]        chg_cnt;
  logic [31:0]       keys_next, sw_next;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= {sw_raw, key_n_raw};
      sync2 <= sync1;
    end
  end

  // Keys are flipped after the synchroniser so every downstream bit is active-high.
  assign synced = sync2 ^ KEY_MASK;

  always_comb begin
    accept = '0;
    for (int i = 0; i < NB; i++) begin
      accept[i] = (synced[i] != stable[i]) && (db_cnt[i] == CNT_LAST);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stable <= '0;
      for (int i = 0; i < NB; i++) db_cnt[i] <= '0;
    end else begin
      stable <= stable ^ accept;
      for (int i = 0; i < NB; i++) begin
        if ((synced[i] == stable[i]) || accept[i]) db_cnt[i] <= '0;
        else                                       db_cnt[i] <= db_cnt[i] + CW'(1);
      end
    end
  end

  // Simultaneous switch changes are a single event.
  always_ff @(posedge clk) begin
    if (reset)                    chg_cnt <= 8'd0;
    else if (|accept[NB-1:N_KEYS]) chg_cnt <= chg_cnt + 8'd1;
  end

`ifdef PIO_KEY_STICKY_EN
  logic              clr_q;
  logic              clr_pulse;
  logic [N_KEYS-1:0] key_rise;

  assign clr_pulse = clr_req & ~clr_q;
  assign key_rise  = accept[N_KEYS-1:0] & synced[N_KEYS-1:0];

  // A press landing on the clear cycle survives the clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      clr_q     <= 1'b0;
      key_flags <= '0;
    end else begin
      clr_q     <= clr_req;
      key_flags <= (key_flags & ~{N_KEYS{clr_pulse}}) | key_rise;
    end
  end
`else
  logic unused_clr;
  assign unused_clr = clr_req;
  assign key_flags  = '0;
`endif

  always_comb begin
    keys_next                = '0;
    keys_next[N_KEYS-1:0]    = stable[N_KEYS-1:0];
    keys_next[8 +: N_KEYS]   = key_flags;
    keys_next[31]            = |key_flags;
    sw_next                  = '0;
    sw_next[N_SW-1:0]        = stable[NB-1:N_KEYS];
    sw_next[31:24]           = chg_cnt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      keys_word     <= '0;
      switches_word <= '0;
    end else begin
      keys_word     <= keys_next;
      switches_word <= sw_next;
    end
  end

endmodule

// File: doc/pio_input_conditioner.md
# pio_input_conditioner

Producer side of the keys/switches PIO input ports of the PCIe core. Takes raw active-low push-buttons and slide switches and synchronises and debounces them. Latches key presses as sticky event flags and counts switch changes. Presents two registered 32-bit words that wire directly to `keysport_external_connection_export` and `switchesport_external_connection_export`. Host software clears the sticky flags by toggling a bit it drives through one of the core's output ports, which closes the read/acknowledge loop.

## Interface
- `N_KEYS`, 4: number of push-buttons, 1..8.
- `N_SW`, 18: number of slide switches, 1..24.
- `DEBOUNCE_CYCLES`, 250000: cycles an input must hold a new level before it is accepted (5 ms at 50 MHz); minimum 2.
- `clk`  in  1  system clock, the same clock as the PCIe core's application side.
- `reset`  in  1  synchronous, active-high reset.
- `key_n_raw`  in  N_KEYS  raw buttons, asynchronous, active-low (0 = pressed).
- `sw_raw`  in  N_SW  raw switches, asynchronous, active-high.
- `clr_req`  in  1  host acknowledge level; each rising edge clears the sticky key flags.
- `keys_word`  out  32  to keysport. [N_KEYS-1:0] = debounced pressed level. [8+N_KEYS-1:8] = sticky press flags. [31] = OR of sticky flags. All other bits are 0.
- `switches_word`  out  32  to switchesport. [N_SW-1:0] = debounced switch level. [31:24] = change counter. All other bits are 0.

## Operation
- Every raw bit passes through a two-flop synchroniser. Key bits are inverted after synchronisation so that 1 means pressed.
- Each bit has its own debouncer with a stable register and a counter of width clog2(DEBOUNCE_CYCLES).
  - If the synced value equals stable, the counter is cleared.
  - Otherwise the counter increments. When it reaches DEBOUNCE_CYCLES-1, stable takes the synced value and the counter is cleared.
  - Glitches shorter than DEBOUNCE_CYCLES never reach stable.
- Sticky key flag k is set on a 0→1 transition of debounced key k. It holds until a clear.
- `clr_req` is registered once. Its rising edge (registered value 0, current value 1) produces a one-cycle clear pulse that zeroes all sticky flags.
- If a clear pulse and a new press of key k occur in the same cycle, the press wins: flag k stays 1. Other flags clear.
- Change counter:
  - Increments by 1 in every cycle in which at least one debounced switch bit changes. Several bits changing in the same cycle count as one.
  - 8-bit, wraps 255→0.
  - Not cleared by `clr_req`.
- Switches are not gated at power-up. A switch that is high at reset reaches stable after debounce and increments the counter.

## Timing
- Every output and every internal register is 0 after reset. This includes sync flops, counters, stable values, flags, the counter and the registered `clr_req`.
- Reset asserted mid-debounce discards all progress. After release, debounce restarts from 0.
- Latency from a raw edge to the output word is 2 (sync) + DEBOUNCE_CYCLES (debounce) + 1 (output register) cycles, provided the raw input holds throughout.
- A sticky flag becomes visible in the same cycle as its debounced level bit, with no extra cycle.
- A clear becomes visible in `keys_word` 2 cycles after `clr_req` rises: 1 cycle for the edge register, 1 for the output register.
- Bit 31 of `keys_word` is derived from the registered flags and is updated in the same cycle as them.
- `clr_req` is driven from the core's clock domain and is not synchronised. Holding it high has no further effect; the next clear requires it to fall and rise again.

## Configuration
- Macro `PIO_KEY_STICKY_EN`.
- Defined: sticky flags, the clear-edge logic and `keys_word[31]` are built as described above.
- Not defined: that logic is not instantiated. `keys_word[8+N_KEYS-1:8]` and `keys_word[31]` read 0, and `clr_req` is ignored. Debounced key levels and all switch behaviour are unchanged.

## Test plan
All scenarios use DEBOUNCE_CYCLES=8.
- **Reset.** Hold `reset` for 3 cycles with key_n_raw=4'hF and sw_raw=0 → `keys_word`=0 and `switches_word`=0 throughout, and still 0 20 cycles after release.
- **Clean key press.** Drive key_n_raw[2]=0 and hold it → `keys_word` becomes 0x8000_0404 exactly 11 cycles after the edge. Then release → `keys_word`=0x8000_0400 after the same latency.
- **Glitch rejection.** Pulse sw_raw[5]=1 for 5 cycles, then return to 0 → `switches_word` stays 0. A second pulse held for 12 cycles → `switches_word`=0x0100_0020, and after it returns low, 0x0200_0000.
- **Clear racing a press.** Key0 flag already set. Raise `clr_req` in the same cycle that debounced key1 rises → 2 cycles later flag bits are 0x2, with key1's flag kept and key0's cleared, and bit 31 is 1. A further rising edge of `clr_req` after key1 is released → `keys_word`=0.
- **Counter wrap.** Toggle sw_raw[0] 256 times, each level held for 12 cycles → `switches_word[31:24]` ends at 0x00 and passes 0xFF on the 255th change.
- **Macro off.** Build without `PIO_KEY_STICKY_EN` and repeat the clean key press → `keys_word`=0x0000_0004, then 0. `clr_req` edges cause no change.
